// File: rtl/dnn_hex_arbiter.sv
// dnn_hex_arbiter: round-robin share of one 7-seg HEX PIO
// between two requesters, with a post-ack display hold.
module dnn_hex_arbiter #(
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned HOLD_W      = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic [3:0]  nibble0,
  output logic        ack0,
  input  logic        req1,
  input  logic [3:0]  nibble1,
  output logic        ack1,
  output logic [1:0]  hex_address,
  output logic        hex_chipselect,
  output logic        hex_write_n,
  output logic [31:0] hex_writedata,
  output logic        busy,
  output logic        last_owner
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    HOLD_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [6:0]        seg_q, seg_d;
  logic              cs_q, cs_d;
  logic              wn_q, wn_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              owner_q, owner_d;
  logic              gnt0, gnt1;

  // Active-low 7-seg pattern, bit0=a .. bit6=g
  function automatic logic [6:0] seg_enc(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // On a tie the requester that did not own the PIO last wins
  always_comb begin
    gnt0 = req0 & (~req1 | owner_q);
    gnt1 = req1 & (~req0 | ~owner_q);
  end

  // Next-state and next-output computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    owner_d = owner_q;
    case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          gnt0: begin
            owner_d = 1'b0;
            seg_d   = seg_enc(nibble0);
            cs_d    = 1'b1;
            wn_d    = 1'b0;
            state_d = S_WRITE;
          end
          gnt1: begin
            owner_d = 1'b1;
            seg_d   = seg_enc(nibble1);
            cs_d    = 1'b1;
            wn_d    = 1'b0;
            state_d = S_WRITE;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_WRITE: begin
        ack0_d  = ~owner_q;
        ack1_d  = owner_q;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (HOLD_CYCLES == 0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = HOLD_LOAD;
          state_d = S_HOLD;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
    endcase
  end

  // State and registered PIO/ack outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      seg_q   <= '0;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      owner_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      cs_q    <= cs_d;
      wn_q    <= wn_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      owner_q <= owner_d;
    end
  end

  assign ack0           = ack0_q;
  assign ack1           = ack1_q;
  assign hex_address    = 2'b00;
  assign hex_chipselect = cs_q;
  assign hex_write_n    = wn_q;
  assign hex_writedata  = {25'b0, seg_q};
  assign busy           = (state_q != S_IDLE);
  assign last_owner     = owner_q;

endmodule

// File: tb/tb_dnn_hex_arbiter.sv
// tb_dnn_hex_arbiter: scoreboard bench, one DUT with
// HOLD_CYCLES=4 and one with HOLD_CYCLES=0.
module tb_dnn_hex_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        req0_a, req1_a, req0_b, req1_b;
  logic [3:0]  nib0_a, nib1_a, nib0_b, nib1_b;
  logic        ack0_a, ack1_a, ack0_b, ack1_b;
  logic [1:0]  addr_a, addr_b;
  logic        cs_a, cs_b, wn_a, wn_b;
  logic [31:0] wd_a, wd_b;
  logic        busy_a, busy_b, lo_a, lo_b;

  dnn_hex_arbiter #(.HOLD_CYCLES(4), .HOLD_W(8)) u_dut_a (
    .clk(clk), .reset_n(rst_a),
    .req0(req0_a), .nibble0(nib0_a), .ack0(ack0_a),
    .req1(req1_a), .nibble1(nib1_a), .ack1(ack1_a),
    .hex_address(addr_a), .hex_chipselect(cs_a),
    .hex_write_n(wn_a), .hex_writedata(wd_a),
    .busy(busy_a), .last_owner(lo_a)
  );

  dnn_hex_arbiter #(.HOLD_CYCLES(0), .HOLD_W(4)) u_dut_b (
    .clk(clk), .reset_n(rst_b),
    .req0(req0_b), .nibble0(nib0_b), .ack0(ack0_b),
    .req1(req1_b), .nibble1(nib1_b), .ack1(ack1_b),
    .hex_address(addr_b), .hex_chipselect(cs_b),
    .hex_write_n(wn_b), .hex_writedata(wd_b),
    .busy(busy_b), .last_owner(lo_b)
  );

  typedef struct packed {
    logic        who;
    logic [31:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int checks   = 0;
  int failures = 0;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [31:0] wdat(input logic [3:0] n);
    return {25'b0, seg_tab[n]};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   wr_a = 0, busy_cnt_a = 0, pend_a_cyc = 0;
  logic pend_a_v = 1'b0, pend_a_who = 1'b0;
  int   strobe_a[$];

  always @(negedge clk) begin
    if (busy_a) busy_cnt_a++;
    if (cs_a && !wn_a) begin
      wr_a++;
      strobe_a.push_back(cyc);
      if (qa.size() == 0) begin
        check("a_unexp_wr", wd_a, 32'hffff_ffff);
      end else begin
        ea = qa.pop_front();
        check("a_wdata", wd_a, ea.data);
        check("a_addr", {30'b0, addr_a}, 0);
        pend_a_v   = 1'b1;
        pend_a_who = ea.who;
        pend_a_cyc = cyc;
      end
    end
    if (ack0_a || ack1_a) begin
      check("a_ack_onehot", {31'b0, ack0_a & ack1_a}, 0);
      if (!pend_a_v) begin
        check("a_unexp_ack", {30'b0, ack1_a, ack0_a}, 0);
      end else begin
        check("a_ack_who", {31'b0, ack1_a}, {31'b0, pend_a_who});
        check("a_ack_lat", cyc - pend_a_cyc, 1);
        check("a_last_owner", {31'b0, lo_a}, {31'b0, pend_a_who});
        pend_a_v = 1'b0;
      end
    end
  end

  int   wr_b = 0, prev_b = -1;
  logic pend_b_v = 1'b0;

  always @(negedge clk) begin
    if (cs_b && !wn_b) begin
      wr_b++;
      if (prev_b >= 0) check("b_spacing", cyc - prev_b, 3);
      prev_b = cyc;
      if (qb.size() == 0) begin
        check("b_unexp_wr", wd_b, 32'hffff_ffff);
      end else begin
        eb = qb.pop_front();
        check("b_wdata", wd_b, eb.data);
        pend_b_v = 1'b1;
      end
    end
    if (ack0_b || ack1_b) begin
      check("b_ack_who", {30'b0, ack1_b, ack0_b}, 1);
      check("b_ack_pend", {31'b0, pend_b_v}, 1);
      pend_b_v = 1'b0;
    end
  end

  task automatic wait_ack(input bit dut, input bit who,
                          input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (!dut && !who && ack0_a) ok = 1'b1;
      if (!dut &&  who && ack1_a) ok = 1'b1;
      if ( dut && !who && ack0_b) ok = 1'b1;
      if ( dut &&  who && ack1_b) ok = 1'b1;
    end
  endtask

  task automatic wait_idle_a(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!busy_a) done = 1'b1;
    end
    check(tag, {31'b0, done}, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int base, rel, k;
    rst_a = 1'b0; rst_b = 1'b0;
    req0_a = 0; req1_a = 0; nib0_a = 0; nib1_a = 0;
    req0_b = 0; req1_b = 0; nib0_b = 0; nib1_b = 0;
    repeat (2) @(negedge clk);
    check("rst_ack", {30'b0, ack1_a, ack0_a}, 0);
    check("rst_cs_wn", {30'b0, cs_a, wn_a}, 1);
    check("rst_wdata", wd_a, 0);
    check("rst_busy", {31'b0, busy_a}, 0);
    check("rst_lo", {31'b0, lo_a}, 1);
    check("rst_b", {28'b0, cs_b, wn_b, busy_b, lo_b}, 5);

    // Tie straight out of reset: 0 first, then 1
    @(posedge clk); #1;
    rst_a = 1'b1; rst_b = 1'b1;
    nib0_a = 4'h0; nib1_a = 4'hF;
    req0_a = 1'b1; req1_a = 1'b1;
    qa.push_back('{1'b0, wdat(4'h0)});
    qa.push_back('{1'b1, wdat(4'hF)});
    strobe_a.delete();
    wait_ack(0, 0, 10, ok);
    check("t2_ack0_seen", {31'b0, ok}, 1);
    @(posedge clk); #1 req0_a = 1'b0;
    wait_ack(0, 1, 20, ok);
    check("t2_ack1_seen", {31'b0, ok}, 1);
    @(posedge clk); #1 req1_a = 1'b0;
    check("t2_nstrobe", strobe_a.size(), 2);
    if (strobe_a.size() >= 2)
      check("t2_spacing", strobe_a[1] - strobe_a[0], 7);
    wait_idle_a("t2_idle");

    // Both held: strict alternation 0,1,0,1,0,1
    strobe_a.delete();
    nib0_a = 4'h3; nib1_a = 4'hA;
    for (int i = 0; i < 6; i++)
      qa.push_back('{i[0], (i[0] ? wdat(4'hA) : wdat(4'h3))});
    req0_a = 1'b1; req1_a = 1'b1;
    k = 0;
    for (int i = 0; i < 100 && k < 6; i++) begin
      @(negedge clk);
      if (ack0_a || ack1_a) k++;
    end
    check("rr_acks", k, 6);
    @(posedge clk); #1;
    req0_a = 1'b0; req1_a = 1'b0;
    check("rr_nstrobe", strobe_a.size(), 6);
    for (int i = 1; i < strobe_a.size(); i++)
      check("rr_spacing", strobe_a[i] - strobe_a[i-1], 7);
    wait_idle_a("rr_idle");

    // Single request, nibble 5, busy length
    busy_cnt_a = 0;
    nib0_a = 4'h5; req0_a = 1'b1;
    qa.push_back('{1'b0, wdat(4'h5)});
    wait_ack(0, 0, 10, ok);
    check("t1_ack0_seen", {31'b0, ok}, 1);
    @(posedge clk); #1 req0_a = 1'b0;
    wait_idle_a("t1_idle");
    check("t1_busy_len", busy_cnt_a, 6);
    check("t1_lo", {31'b0, lo_a}, 0);

    // req1 pulsed during HOLD is ignored
    base = wr_a;
    nib0_a = 4'h7; req0_a = 1'b1;
    qa.push_back('{1'b0, wdat(4'h7)});
    wait_ack(0, 0, 10, ok);
    check("hp_ack0_seen", {31'b0, ok}, 1);
    @(posedge clk); #1 req0_a = 1'b0;
    @(posedge clk); #1 req1_a = 1'b1; nib1_a = 4'h2;
    @(posedge clk); #1 req1_a = 1'b0;
    repeat (12) @(negedge clk);
    check("hp_writes", wr_a - base, 1);
    check("hp_busy", {31'b0, busy_a}, 0);

    // Repeated single requester, HOLD_CYCLES=0
    for (int n = 0; n < 16; n++) begin
      qb.push_back('{1'b0, wdat(4'(n))});
      nib0_b = 4'(n); req0_b = 1'b1;
      wait_ack(1, 0, 10, ok);
      check("b_ack_seen", {31'b0, ok}, 1);
      @(posedge clk); #1 req0_b = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("b_nwrites", wr_b, 16);

    // Reset during the WRITE cycle
    nib1_a = 4'h9; req1_a = 1'b1;
    qa.push_back('{1'b1, wdat(4'h9)});
    qa.push_back('{1'b1, wdat(4'h9)});
    base = wr_a;
    @(posedge clk);
    @(negedge clk);
    #1 rst_a = 1'b0;
    #1;
    check("mr_wrote", wr_a - base, 1);
    check("mr_cs_wn", {30'b0, cs_a, wn_a}, 1);
    check("mr_ack1", {31'b0, ack1_a}, 0);
    check("mr_busy", {31'b0, busy_a}, 0);
    check("mr_lo", {31'b0, lo_a}, 1);
    strobe_a.delete();
    @(posedge clk);
    @(negedge clk);
    #1 rst_a = 1'b1;
    rel = cyc;
    wait_ack(0, 1, 10, ok);
    check("mr_ack1_seen", {31'b0, ok}, 1);
    @(posedge clk); #1 req1_a = 1'b0;
    check("mr_nstrobe", strobe_a.size(), 1);
    if (strobe_a.size() >= 1)
      check("mr_lat_ok", {31'b0, (strobe_a[0] - rel) <= 2}, 1);
    wait_idle_a("mr_idle");

    check("qa_empty", qa.size(), 0);
    check("qb_empty", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dnn_hex_arbiter.md
# dnn_hex_arbiter

Round-robin arbiter and sequencer that shares one 7-segment HEX PIO slave between two requesters in the DNN accelerator system. Each requester hands over a 4-bit value. The block encodes it to an active-low 7-segment pattern and issues a single Avalon-MM write to PIO address 0. It then acknowledges the requester and enforces a minimum display hold time before granting again.

## Interface
Parameters:
- HOLD_CYCLES, 1000, idle cycles enforced after each ACK before the next grant; 0 allowed
- HOLD_W, 32, width of the hold counter; must hold HOLD_CYCLES

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- req0  in  1  requester 0 request; level, held until ack0
- nibble0  in  4  requester 0 value; stable while req0=1
- ack0  out  1  one-cycle acknowledge to requester 0
- req1  in  1  requester 1 request
- nibble1  in  4  requester 1 value
- ack1  out  1  one-cycle acknowledge to requester 1
- hex_address  out  2  PIO address; always 0
- hex_chipselect  out  1  PIO chipselect
- hex_write_n  out  1  PIO write strobe, active-low
- hex_writedata  out  32  {25'b0, seg[6:0]}
- busy  out  1  1 in any state other than IDLE
- last_owner  out  1  index of the most recently granted requester

## Operation
- Reset values:
  - ack0=ack1=0, hex_chipselect=0, hex_write_n=1.
  - hex_address=0, hex_writedata=0, busy=0.
  - last_owner=1, so requester 0 wins the first tie.
  - State resets to IDLE and the hold counter to 0.
- FSM states: IDLE, WRITE, ACK, HOLD.
- IDLE:
  - If no req is set, remain in IDLE.
  - If exactly one req is set, grant that requester.
  - If both are set, grant the requester other than last_owner.
  - On grant, latch the granted nibble, encode it, and set last_owner to the grant index. Next state is WRITE.
- WRITE: for exactly one cycle drive hex_chipselect=1, hex_write_n=0, hex_address=0 and hex_writedata={25'b0,seg}. The PIO has no waitrequest, so the write completes in this cycle. Next state is ACK.
- ACK: strobes return to idle levels and the granted ack is 1 for one cycle.
  - If HOLD_CYCLES=0, go to IDLE.
  - Otherwise load the counter with HOLD_CYCLES-1 and go to HOLD.
- HOLD: decrement the counter each cycle. When it reaches 0, go to IDLE. req inputs are ignored in HOLD.
- hex_writedata holds its last value between writes; only hex_chipselect and hex_write_n qualify it.
- Segment encoding, active-low, bit0=a … bit6=g:
  - 0:40, 1:79, 2:24, 3:30
  - 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03
  - C:46, d:21, E:06, F:0E
- Requester rules:
  - A requester deasserts req on the clock edge at which it samples ack=1.
  - A req dropped before grant has no effect.
  - A nibble change while req is held before grant uses the value present at the grant edge.

## Timing
- Timeline for a request in IDLE sampled at edge E:
  - The write strobe is valid in the cycle after E.
  - ack is valid in the cycle after the strobe.
  - Request-to-ack latency is 2 cycles.
- Strobe-to-strobe spacing under continuous requests is HOLD_CYCLES+3 cycles.
- Simultaneous req0/req1 alternate strictly: 0,1,0,1…
- A single requester requesting repeatedly is re-granted even though it is last_owner.
- Reset asserted mid-operation (any state):
  - All outputs immediately take their reset values.
  - A pending ack is lost. The requester keeps req high and is re-served after reset.
  - A write already completed on the PIO is not undone.
- Exactly one of ack0/ack1 may be high in any cycle. hex_chipselect=1 for exactly one cycle per grant.

## Test plan
- HOLD_CYCLES=4, req0=1 with nibble0=5 from IDLE:
  - Writedata is 0x12 with cs=1, write_n=0 for exactly 1 cycle.
  - ack0=1 the next cycle. busy stays high for 6 cycles in total, then returns low.
- Both reqs asserted in the first cycle after reset, nibble0=0, nibble1=F:
  - First write is 0x40 followed by ack0.
  - Second write is 0x0E followed by ack1, 7 cycles after the first strobe.
- HOLD_CYCLES=0, req0 re-asserted immediately after each ack for nibbles 0..F:
  - The 16 writes match the encoding table.
  - Strobes are spaced exactly 3 cycles apart.
- Both reqs held continuously for 6 grants: grant order is 0,1,0,1,0,1 and last_owner tracks each grant.
- Assert reset_n=0 during the WRITE cycle with req1 set:
  - cs=0, write_n=1, ack1=0, busy=0 and last_owner=1 immediately.
  - After release, req1 is served with the correct pattern within 2 cycles.
- Pulse req1 for one cycle during HOLD, then drop it: no additional write and no ack1 occurs.
